// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg -- shared defines for the RAM arbiter slice.
//   arb_state_e      : arbiter FSM state encoding
//   TIMEOUT_DEFAULT  : default BUSY-cycle budget before a transaction is aborted
//   OP_*             : RAM access op codes shared with the load/store unit
//   cnt_width()      : width of a counter spanning 0..t-1 (min 1 bit)
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT = 64;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  function automatic int cnt_width(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// rr_arbiter2 -- two-way round-robin selector, purely combinational.
//   req[1:0]   : request lines (bit1 = requester 1)
//   last       : 1 when requester 1 won the previous grant
//   grant[1:0] : one-hot winner, 0 when nobody requests
// On a tie the requester that did not win last time is chosen.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant    = '0;
    grant[1] = req[1] & (~req[0] | ~last);
    grant[0] = req[0] & (~req[1] |  last);
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter -- shares one RAM port between the fetch requester (m0) and
// the MEM-stage requester (m1).
//   clk_i, rst_i             : clock, synchronous active-low reset
//   m*_req/we/addr/wdata/op  : requester transaction (held until ack)
//   m*_ack_o/err_o/rdata_o   : one-cycle completion, timeout flag, read data
//   ram_*_o, ram_data_i/ready_i : RAM port
//   grant_o                  : one-hot owner of the transaction in flight
// Flow: IDLE -(any req, grant)-> BUSY -(ready or timeout)-> RESP -> IDLE.
// The winner's payload is latched at grant so the RAM sees a stable request
// even if the requester changes its inputs or drops req afterwards.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  input  logic [3:0]            m0_op_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  input  logic [3:0]            m1_op_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  ram_request_o,
  output logic                  ram_w_request_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic [3:0]            ram_op_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  input  logic                  ram_ready_i,
  output logic [1:0]            grant_o
);

  localparam int             CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit             TO_EN    = (TIMEOUT != 0);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            op;
  } req_t;

  req_t [1:0]                 req_in;
  logic [1:0]                 req_vec;
  logic [1:0]                 rr_gnt;

  arb_state_e                 state_q;
  req_t                       cur_q;
  logic [1:0]                 grant_q;
  logic                       last_q;   // 1: m1 won the last grant
  logic [CW-1:0]              cnt_q;
  logic [1:0]                 ack_q;
  logic [1:0]                 err_q;
  logic [1:0][DATA_WIDTH-1:0] rdata_q;

  logic                       owner;
  logic                       busy;
  logic                       timeout_hit;

  assign req_in[0] = {m0_we_i, m0_addr_i, m0_wdata_i, m0_op_i};
  assign req_in[1] = {m1_we_i, m1_addr_i, m1_wdata_i, m1_op_i};
  assign req_vec   = {m1_req_i, m0_req_i};

  rr_arbiter2 u_rr (
    .req   (req_vec),
    .last  (last_q),
    .grant (rr_gnt)
  );

  assign owner       = grant_q[1];
  assign busy        = (state_q == ST_BUSY);
  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      grant_q <= '0;
      last_q  <= 1'b0;   // m1 wins the first tie after reset
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (|req_vec) begin
            grant_q <= rr_gnt;
            last_q  <= rr_gnt[1];
            cur_q   <= rr_gnt[1] ? req_in[1] : req_in[0];
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // ready has priority over a timeout landing on the same cycle
          if (ram_ready_i) begin
            if (!cur_q.we) rdata_q[owner] <= ram_data_i;
            ack_q[owner] <= 1'b1;
            state_q      <= ST_RESP;
          end else if (timeout_hit) begin
            rdata_q[owner] <= '0;
            ack_q[owner]   <= 1'b1;
            err_q[owner]   <= 1'b1;
            state_q        <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RESP: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m0_ack_o   = ack_q[0];
  assign m1_ack_o   = ack_q[1];
  assign m0_err_o   = err_q[0];
  assign m1_err_o   = err_q[1];
  assign m0_rdata_o = rdata_q[0];
  assign m1_rdata_o = rdata_q[1];
  assign grant_o    = grant_q;

  // RAM side is quiet outside BUSY; payload comes from the latched request.
  assign ram_request_o   = busy;
  assign ram_w_request_o = busy & cur_q.we;
  assign ram_addr_o      = busy ? cur_q.addr  : '0;
  assign ram_data_o      = busy ? cur_q.wdata : '0;
  assign ram_op_o        = busy ? cur_q.op    : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed steps in one initial block; every expected
// completion is queued when its request is driven and checked by a monitor
// when an ack appears on the TIMEOUT=64 instance. A second instance with
// TIMEOUT=4 shares the inputs and is checked directly in the timeout steps.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          m0_req_i = 0, m0_we_i = 0, m1_req_i = 0, m1_we_i = 0;
  logic [AW-1:0] m0_addr_i = '0, m1_addr_i = '0;
  logic [DW-1:0] m0_wdata_i = '0, m1_wdata_i = '0, ram_data_i = '0;
  logic [3:0]    m0_op_i = '0, m1_op_i = '0;
  logic          ram_ready_i = 1'b0;

  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          ram_request_o, ram_w_request_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_data_o;
  logic [3:0]    ram_op_o;
  logic [1:0]    grant_o;

  logic          t_m0_ack, t_m0_err, t_m1_ack, t_m1_err;
  logic [DW-1:0] t_m0_rdata, t_m1_rdata;
  logic          t_ram_request, t_ram_w_request;
  logic [AW-1:0] t_ram_addr;
  logic [DW-1:0] t_ram_data;
  logic [3:0]    t_ram_op;
  logic [1:0]    t_grant;

  always #5 clk_i = ~clk_i;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_op_i(m0_op_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_op_i(m1_op_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
    .ram_request_o(ram_request_o), .ram_w_request_o(ram_w_request_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_op_o(ram_op_o),
    .ram_data_i(ram_data_i), .ram_ready_i(ram_ready_i), .grant_o(grant_o)
  );

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut_t (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_op_i(m0_op_i),
    .m0_ack_o(t_m0_ack), .m0_err_o(t_m0_err), .m0_rdata_o(t_m0_rdata),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_op_i(m1_op_i),
    .m1_ack_o(t_m1_ack), .m1_err_o(t_m1_err), .m1_rdata_o(t_m1_rdata),
    .ram_request_o(t_ram_request), .ram_w_request_o(t_ram_w_request),
    .ram_addr_o(t_ram_addr), .ram_data_o(t_ram_data), .ram_op_o(t_ram_op),
    .ram_data_i(ram_data_i), .ram_ready_i(ram_ready_i), .grant_o(t_grant)
  );

  typedef struct {
    logic [1:0]    who;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, 64'(grant_o), 64'd0);
    chk({tag, "_ramreq"}, 64'({ram_request_o, ram_w_request_o}), 64'd0);
    chk({tag, "_ramaddr"}, 64'(ram_addr_o), 64'd0);
    chk({tag, "_ramdata"}, 64'(ram_data_o), 64'd0);
    chk({tag, "_ramop"}, 64'(ram_op_o), 64'd0);
    chk({tag, "_ackerr"}, 64'({m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}), 64'd0);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int n = 0;
    while (!(m0_ack_o || m1_ack_o) && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 64'(m0_ack_o | m1_ack_o), 64'd1);
  endtask

  // Scoreboard: every ack on the main instance must match the oldest
  // queued expectation; an ack with nothing queued is an error.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (m0_ack_o || m1_ack_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 64'({m1_ack_o, m0_ack_o}), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_who", 64'({m1_ack_o, m0_ack_o}), 64'(e.who));
        chk("sb_rdata", 64'(e.who[1] ? m1_rdata_o : m0_rdata_o), 64'(e.rdata));
        chk("sb_err", 64'({m1_err_o, m0_err_o}), e.err ? 64'(e.who) : 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- reset state
    cyc(); cyc();
    chk_quiet("rst");
    chk("rst_rdata", 64'({m1_rdata_o, m0_rdata_o}), 64'd0);
    rst_i = 1'b1;

    // ---- m1 alone reads 0x100, ready already high (ignored while IDLE)
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h100; m1_op_i = OP_LW;
    ram_ready_i = 1; ram_data_i = 32'hDEADBEEF;
    sb.push_back('{2'b10, 32'hDEADBEEF, 1'b0});
    cyc();
    chk("r36_grant", 64'(grant_o), 64'b10);
    chk("r36_ramreq", 64'({ram_request_o, ram_w_request_o}), 64'b10);
    chk("r36_addr", 64'(ram_addr_o), 64'h100);
    chk("r36_op", 64'(ram_op_o), 64'(OP_LW));
    chk("r36_early_ack", 64'(m1_ack_o), 64'd0);
    cyc();
    chk("r36_ack", 64'({m1_ack_o, m0_ack_o}), 64'b10);
    chk("r36_m0_rdata", 64'(m0_rdata_o), 64'd0);
    m1_req_i = 0; ram_ready_i = 0;
    cyc();
    chk_quiet("r36_idle");

    // ---- simultaneous requests right after reset: m1 first, then m0
    rst_i = 0; cyc(); rst_i = 1;
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h10; m0_op_i = OP_LW;
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h20; m1_op_i = OP_LW;
    ram_ready_i = 1; ram_data_i = 32'hA5A50001;
    sb.push_back('{2'b10, 32'hA5A50001, 1'b0});
    sb.push_back('{2'b01, 32'hA5A50000, 1'b0});
    cyc();
    chk("r37_grant1", 64'(grant_o), 64'b10);
    chk("r37_addr1", 64'(ram_addr_o), 64'h20);
    cyc();
    chk("r37_ack1", 64'({m1_ack_o, m0_ack_o}), 64'b10);
    m1_req_i = 0; ram_data_i = 32'hA5A50000;
    cyc();
    chk("r37_idle_grant", 64'(grant_o), 64'd0);
    chk("r37_idle_ramreq", 64'(ram_request_o), 64'd0);
    cyc();
    chk("r37_grant0", 64'(grant_o), 64'b01);
    chk("r37_addr0", 64'(ram_addr_o), 64'h10);
    cyc();
    chk("r37_ack0", 64'({m1_ack_o, m0_ack_o}), 64'b01);
    m0_req_i = 0; ram_ready_i = 0;
    cyc();

    // ---- m1 SW write with ready delayed 5 cycles; rdata must not change
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h200; m1_wdata_i = 32'h12345678;
    m1_op_i = OP_SW; ram_data_i = 32'hFFFFFFFF;
    sb.push_back('{2'b10, 32'hA5A50001, 1'b0});
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("r38_ramreq_%0d", i), 64'({ram_request_o, ram_w_request_o}), 64'b11);
      chk($sformatf("r38_addr_%0d", i), 64'(ram_addr_o), 64'h200);
      chk($sformatf("r38_data_%0d", i), 64'(ram_data_o), 64'h12345678);
      chk($sformatf("r38_op_%0d", i), 64'(ram_op_o), 64'(OP_SW));
      chk($sformatf("r38_noack_%0d", i), 64'(m1_ack_o), 64'd0);
      if (i == 5) ram_ready_i = 1;
    end
    cyc();
    chk("r38_ack", 64'({m1_ack_o, m0_ack_o}), 64'b10);
    m1_req_i = 0; m1_we_i = 0; ram_ready_i = 0;
    cyc();

    // ---- TIMEOUT=4: ready on the 4th BUSY cycle beats the timeout
    rst_i = 0; cyc(); rst_i = 1;
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h40; m0_op_i = OP_LW;
    ram_data_i = 32'h55;
    sb.push_back('{2'b01, 32'h55, 1'b0});
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("tie_noack_%0d", i), 64'(t_m0_ack), 64'd0);
      if (i == 3) ram_ready_i = 1;
    end
    cyc();
    chk("tie_ack", 64'({t_m0_err, t_m0_ack}), 64'b01);
    chk("tie_rdata", 64'(t_m0_rdata), 64'h55);
    m0_req_i = 0; ram_ready_i = 0;
    cyc();

    // ---- TIMEOUT=4: ready never comes -> err ack after 4 BUSY cycles
    m0_req_i = 1; m0_addr_i = 32'h44;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("to_noack_%0d", i), 64'(t_m0_ack), 64'd0);
    end
    cyc();
    chk("to_ackerr", 64'({t_m0_err, t_m0_ack}), 64'b11);
    chk("to_rdata", 64'(t_m0_rdata), 64'd0);
    chk("to_m1_quiet", 64'({t_m1_err, t_m1_ack}), 64'd0);
    m0_req_i = 0;
    cyc();
    chk("to_one_cycle", 64'({t_m0_err, t_m0_ack}), 64'd0);

    // ---- reset in the 2nd BUSY cycle abandons; the held req then completes
    rst_i = 0; cyc(); rst_i = 1;
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h300; m1_op_i = OP_LH;
    cyc();
    chk("r40_busy", 64'(ram_request_o), 64'd1);
    cyc();
    rst_i = 0;
    cyc();
    chk_quiet("r40_rst");
    chk("r40_rdata", 64'({m1_rdata_o, m0_rdata_o}), 64'd0);
    rst_i = 1; ram_ready_i = 1; ram_data_i = 32'h0BADF00D;
    sb.push_back('{2'b10, 32'h0BADF00D, 1'b0});
    wait_ack("r40_ack", 10);
    m1_req_i = 0; ram_ready_i = 0;
    cyc(); cyc();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 ADDR_WIDTH, 32, address width of both requester ports and the RAM port.
REQ-002 DATA_WIDTH, 32, data width of both requester ports and the RAM port.
REQ-003 TIMEOUT, 64, BUSY cycles allowed before a transaction is aborted with error; 0 disables the timeout.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-low.
REQ-006 m0_req_i / m1_req_i  in  1  requester 0 (fetch) / requester 1 (MEM stage) transaction request.
REQ-007 m0_we_i / m1_we_i  in  1  write enable of the requested transaction.
REQ-008 m0_addr_i / m1_addr_i  in  ADDR_WIDTH  transaction address.
REQ-009 m0_wdata_i / m1_wdata_i  in  DATA_WIDTH  write data.
REQ-010 m0_op_i / m1_op_i  in  4  access op code (SB/SH/SW/LB/LBU/LH/LHU/LW encoding from the shared defines).
REQ-011 m0_ack_o / m1_ack_o  out  1  one-cycle completion pulse.
REQ-012 m0_err_o / m1_err_o  out  1  one-cycle timeout flag, coincident with ack.
REQ-013 m0_rdata_o / m1_rdata_o  out  DATA_WIDTH  read data, valid during ack.
REQ-014 ram_request_o, ram_w_request_o  out  1 each  RAM access request and write qualifier.
REQ-015 ram_addr_o / ram_data_o  out  ADDR_WIDTH / DATA_WIDTH  RAM address / write data.
REQ-016 ram_op_o  out  4  RAM access op code.
REQ-017 ram_data_i  in  DATA_WIDTH  RAM read data; ram_ready_i  in  1  RAM completion.
REQ-018 grant_o  out  2  one-hot owner of the current transaction (bit1 = m1); 0 when idle.

Function
REQ-019 The FSM SHALL have states IDLE, BUSY, RESP; IDLE->BUSY on any req, BUSY->RESP on ram_ready_i or timeout, RESP->IDLE unconditionally.
REQ-020 In IDLE with one requester asserting req, that requester SHALL be granted at the clock edge; with both asserting, the requester not granted most recently SHALL win (round-robin).
REQ-021 After reset the round-robin pointer SHALL give m1 priority on the first simultaneous request.
REQ-022 At grant, the winner's we/addr/wdata/op SHALL be registered; RAM outputs SHALL drive these registered values throughout BUSY, stable until completion.
REQ-023 ram_request_o SHALL be 1 only in BUSY; ram_w_request_o SHALL equal the registered we in BUSY, else 0; ram_addr_o, ram_data_o, ram_op_o SHALL be 0 outside BUSY.
REQ-024 ram_ready_i sampled 1 in BUSY SHALL capture ram_data_i into the winner's rdata register and enter RESP.
REQ-025 In RESP the winner's ack_o SHALL be 1 for exactly one cycle; the other requester's ack_o SHALL stay 0.
REQ-026 Latency: req sampled in IDLE at edge N gives ram_request_o in cycle N+1; ready in cycle N+1 gives ack in cycle N+2; minimum 3 cycles between grants.
REQ-027 Requesters SHALL hold req and payload until ack; req high in IDLE is a new transaction. A req dropped after grant SHALL not abort; ack is still issued.
REQ-028 A BUSY cycle counter SHALL reset at grant; if it reaches TIMEOUT-1 with ram_ready_i 0 (TIMEOUT != 0), the FSM SHALL enter RESP with err_o=1, rdata=0.
REQ-029 ram_ready_i asserted outside BUSY SHALL be ignored.
REQ-030 rdata_o SHALL hold its last captured value between acks; write transactions SHALL leave it unchanged.
REQ-031 ram_ready_i and timeout in the same cycle: ready SHALL win, err_o=0.

Reset
REQ-032 With rst_i=0 at an edge: state IDLE, grant_o=0, all ack/err=0, all rdata=0, RAM outputs=0, counter=0, pointer favours m1.
REQ-033 Reset during BUSY SHALL abandon the transaction with no ack or err to either requester.

Structure
REQ-034 State encodings and the TIMEOUT default SHALL be added to the shared defines file; op codes SHALL be reused from it.
REQ-035 Two-way round-robin selection SHALL be a sub-module rr_arbiter2 (req[1:0], last-grant pointer in, one-hot grant out, combinational).

Verification
REQ-036 m1 alone reads addr 0x100, RAM ready at first BUSY cycle with 0xDEADBEEF -> m1_ack_o and m1_rdata_o=0xDEADBEEF two cycles after req, m0 untouched.
REQ-037 m0 and m1 req same cycle after reset -> m1 granted first, m0 granted in the IDLE following m1's RESP.
REQ-038 m1 writes SW 0x12345678 to 0x200 with ready delayed 5 cycles -> ram_w_request_o=1 and payload stable all 6 BUSY cycles, one ack.
REQ-039 TIMEOUT=4, ready never asserted -> after 4 BUSY cycles m0_ack_o=1, m0_err_o=1, m0_rdata_o=0.
REQ-040 rst_i=0 in second BUSY cycle -> next cycle all outputs 0, no ack; subsequent request completes normally.
